// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared sizing for the register-file writeback arbiter.
// Defaults match the RegisterFile port widths.
package regfile_wr_arbiter_pkg;

  localparam int WB_ADDR_W  = 5;
  localparam int WB_DATA_W  = 32;
  localparam int NUM_WB_REQ = 3;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after last winner.
// Reusable for any N-way arbitration with an internally held pointer.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW:0] NV = (LW+1)'(N);
  localparam logic [LW-1:0] LAST_RST = LW'(N-1);

  logic [LW-1:0] last_q;
  logic [LW-1:0] last_d;
  logic [LW:0]   j;
  logic          found;

  always_comb begin
    grant  = '0;
    last_d = last_q;
    j      = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = {1'b0, last_q} + (LW+1)'(k);
      if (j >= NV) j = j - NV;
      if (!found && req[j[LW-1:0]]) begin
        found             = 1'b1;
        grant[j[LW-1:0]]  = 1'b1;
        last_d            = j[LW-1:0];
      end
    end
    if (!advance) last_d = last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_RST;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port among writeback sources.
// One holding buffer per source, round-robin drain, pending-rd mask.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_WB_REQ,
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
) (
  input  logic                          Wrclk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0]         Rw,
  output logic [DATA_WIDTH-1:0]         busW,
  output logic                          RegWr,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [2**ADDR_WIDTH-1:0]      pend_mask
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    pend_v_q;
  logic [NUM_REQ-1:0]    pend_v_d;
  logic [ADDR_WIDTH-1:0] pend_rd_q   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] pend_rd_d   [NUM_REQ];
  logic [DATA_WIDTH-1:0] pend_data_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] pend_data_d [NUM_REQ];

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    acc;
  logic [ADDR_WIDTH-1:0] rd_in;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (Wrclk),
    .rst_n   (rst_n),
    .req     (pend_v_q),
    .advance (1'b1),
    .grant   (grant)
  );

  assign req_ready = ~pend_v_q | grant;
  assign acc       = req_valid & req_ready;

  // Writes to x0 are accepted but never buffered.
  always_comb begin
    pend_v_d = pend_v_q;
    rd_in    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_rd_d[i]   = pend_rd_q[i];
      pend_data_d[i] = pend_data_q[i];
      rd_in          = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (grant[i]) pend_v_d[i] = 1'b0;
      if (acc[i] && rd_in != '0) begin
        pend_v_d[i]    = 1'b1;
        pend_rd_d[i]   = rd_in;
        pend_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    RegWr    = |grant;
    Rw       = '0;
    busW     = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        Rw       = pend_rd_q[i];
        busW     = pend_data_q[i];
        grant_id = IW'(i);
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_v_q[i]) pend_mask[pend_rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge Wrclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_rd_q[i]   <= '0;
        pend_data_q[i] <= '0;
      end
    end else begin
      pend_v_q <= pend_v_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_rd_q[i]   <= pend_rd_d[i];
        pend_data_q[i] <= pend_data_d[i];
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of `RegisterFile` (`Rw`/`busW`/`RegWr`) among several writeback sources, e.g. ALU, load unit and CSR unit. Each source hands over one write through a valid/ready handshake into its own one-entry holding buffer. A round-robin arbiter picks one buffered write per cycle and drives it onto the register-file write port. The block also exports a pending-write mask over all architectural registers so issue logic can detect RAW hazards on writes that are accepted but not yet committed.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters (2..8).
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (5): register address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): register data width.

Ports:
- `Wrclk`  in  1: the single clock, same clock as `RegisterFile`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: requester i offers a write.
- `req_ready`  out  NUM_REQ: requester i's buffer can accept a write this cycle.
- `req_rd`  in  NUM_REQ*ADDR_WIDTH: destination register; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NUM_REQ*DATA_WIDTH: write data, packed the same way.
- `Rw`  out  ADDR_WIDTH: write address to the register file.
- `busW`  out  DATA_WIDTH: write data to the register file.
- `RegWr`  out  1: write enable to the register file.
- `grant_id`  out  $clog2(NUM_REQ): index of the requester driving the port; valid only while `RegWr`=1.
- `pend_mask`  out  2**ADDR_WIDTH: bit r=1 while any buffer holds a write to register r.

## Operation
- **Per-requester state:** `pend_v[i]`, `pend_rd[i]`, `pend_data[i]`.
- **Accept:** a write is accepted on a rising `Wrclk` edge when `req_valid[i] & req_ready[i]`.
- **Ready:** `req_ready[i] = ~pend_v[i] | grant[i]`. A buffer granted this cycle refills on the same edge, so one requester can sustain one write per cycle when uncontested.
- **Writes to x0:** an accepted write with `req_rd`=0 is discarded. The buffer is not loaded and no port cycle is used. `req_ready` behaves normally.
- **Arbitration:** combinational round-robin over `pend_v`.
  - Search starts at `last+1` (mod NUM_REQ) and wraps.
  - `last` updates to the granted index on each edge where a grant occurs; otherwise it holds.
  - `grant` is one-hot, or zero if no buffer is valid.
  - The arbiter never looks at `req_valid`, so there is no combinational path from `req_valid` to `req_ready`.
- **Port drive:**
  - `RegWr = |grant`; `Rw`/`busW` = `pend_rd`/`pend_data` of the granted buffer.
  - `Rw`/`busW` = 0 when `RegWr`=0.
  - The granted buffer's `pend_v` clears on the edge, unless it is refilled on that same edge.
- **Pending mask:** `pend_mask[r] = OR over i of (pend_v[i] & pend_rd[i]==r)`. Bit 0 is always 0.
- **Ordering:** writes to different registers commit in grant order.
  - Upstream must not have two uncommitted writes to the same rd in different requesters. The block does not reorder or merge them.
  - Within one requester, order is preserved.
- **Reset (async assert, any time):**
  - All `pend_v`=0; buffered writes are dropped.
  - `last`=NUM_REQ-1, so requester 0 has priority first.
  - Outputs during and after reset: `RegWr`=0, `Rw`=0, `busW`=0, `grant_id`=0, `pend_mask`=0, `req_ready`=all ones.

## Timing
- **Latency:** a write accepted at edge k drives `RegWr` in cycle k..k+1 when uncontested. `RegisterFile` commits it at edge k+1, and its read bypass forwards it during cycle k..k+1.
- **Contention:** with M buffers valid, a given buffer waits at most M-1 cycles for grant.
- **Throughput:** one register-file write per cycle at most.
- **Ready timing:** `req_ready` depends only on registered state and `grant`, both derived from state.
- **`pend_mask`:** registered-state-derived. A bit clears in the cycle after the write's commit edge, unless it is refilled.
- **Simultaneous grant and refill of the same buffer on one edge:** the old entry is written to the port; the new entry is loaded.

## Structure
- **Shared package/define:** reuse `` `ADDR_WIDTH `` / `` `DATA_WIDTH `` from `define.v`, and add `` `NUM_WB_REQ ``.
- **Sub-module:** one sub-module, `rr_arbiter` (parameter N; inputs `req`[N], `advance`; output `grant`[N] one-hot; holds `last` internally). It is reusable for future bus and CSR arbitration.
- **Top level:** buffers, mux, and `pend_mask` decode stay in the top.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic with 3 buffers full → `RegWr`=0, `pend_mask`=0, all `req_ready`=1. After release, no stale write appears.
- **Single requester, back-to-back:** req1 writes x5=0x11, x6=0x22, x7=0x33 on consecutive cycles → `RegWr`=1 for three consecutive cycles with Rw=5,6,7, `req_ready[1]` stays 1, and RF reads back the values.
- **Fairness:** all 3 requesters valid continuously → `grant_id` sequence 0,1,2,0,1,2. No requester waits more than 2 cycles.
- **x0 discard:** req0 writes x0=0xDEAD → accepted, `RegWr` never asserted, `pend_mask` stays 0.
- **Contention and hazard mask:** req0 targets x3 and req2 targets x9 on the same edge → next cycle `pend_mask` has bits 3 and 9 set. Grant goes to req0, then req2. Bit 3 clears one cycle before bit 9.
- **Refill on grant:** req2 is granted while `req_valid[2]` holds a new x4 → `req_ready[2]`=1 that cycle, the new entry is latched, and it is written the following cycle.
